// File: rtl/pc_high.sv
// Program Counter High byte: PCHS select, carry-in increment, PCH register
// and the one-cycle relative-branch page-crossing fixup sequencer.
module pc_high #(
    parameter logic [7:0] RESET_PCH = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pch_pch,
    input  logic       i_adh_pch,
    input  logic [7:0] i_adh,
    input  logic       i_pclc,
    input  logic       i_branch_fix,
    input  logic       i_branch_carry,
    input  logic       i_branch_neg,
    output logic [7:0] o_pch,
    output logic       o_pchc,
    output logic       o_page_cross
);

    typedef enum logic {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] pch, pch_nxt;
    logic       dir, dir_nxt;
    logic [7:0] pchs;
    logic [8:0] sum;
    logic       need;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            pch   <= RESET_PCH;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            pch   <= pch_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        pchs         = '0;
        sum          = '0;
        need         = 1'b0;
        state_nxt    = state;
        pch_nxt      = pch;
        dir_nxt      = dir;
        o_pchc       = 1'b0;
        o_page_cross = 1'b0;

        if (i_pch_pch)
            pchs = pch;
        else if (i_adh_pch)
            pchs = i_adh;

        sum = {1'b0, pchs} + {8'h00, i_pclc};

        unique case (state)
            IDLE: begin
                o_pchc  = sum[8];
                pch_nxt = sum[7:0];
                // Page crossed when the PCL carry disagrees with the offset sign.
                need    = i_branch_fix & (i_branch_carry ^ i_branch_neg);
                if (need) begin
                    state_nxt = FIX;
                    dir_nxt   = i_branch_neg;
                end
            end
            FIX: begin
                o_page_cross = 1'b1;
                pch_nxt      = dir ? (pch - 8'd1) : (pch + 8'd1);
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_pch = pch;

endmodule

// File: tb/tb_pc_high.sv
// Self-checking bench for pc_high: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_pc_high;

    logic       clk = 1'b0;
    logic       reset;
    logic       pch_pch, adh_pch, pclc, branch_fix, branch_carry, branch_neg;
    logic [7:0] adh;
    logic [7:0] o_pch;
    logic       o_pchc, o_page_cross;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int m_pch;
    bit m_fixing;
    int m_step;
    bit m_valid = 1'b0;

    pc_high #(.RESET_PCH(8'h00)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pch_pch     (pch_pch),
        .i_adh_pch     (adh_pch),
        .i_adh         (adh),
        .i_pclc        (pclc),
        .i_branch_fix  (branch_fix),
        .i_branch_carry(branch_carry),
        .i_branch_neg  (branch_neg),
        .o_pch         (o_pch),
        .o_pchc        (o_pchc),
        .o_page_cross  (o_page_cross)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_select();
        if (pch_pch) return m_pch;
        if (adh_pch) return int'(adh);
        return 0;
    endfunction

    // Reference model: PC high byte as an integer 0..255.
    always @(posedge clk) begin
        if (reset) begin
            m_pch    <= 0;
            m_fixing <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_fixing) begin
            m_pch    <= (m_pch + m_step + 256) % 256;
            m_fixing <= 1'b0;
        end else begin
            m_pch <= (model_select() + int'(pclc)) % 256;
            // A forward offset with carry, or a backward offset without, leaves the page.
            if (branch_fix && (branch_carry != branch_neg)) begin
                m_fixing <= 1'b1;
                m_step   <= branch_neg ? -1 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pch", int'(o_pch), m_pch);
            chk("model_page_cross", int'(o_page_cross), int'(m_fixing));
            chk("model_pchc", int'(o_pchc),
                (!m_fixing && (model_select() + int'(pclc) > 255)) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reset = 0; pch_pch = 0; adh_pch = 0; adh = 8'h00; pclc = 0;
        branch_fix = 0; branch_carry = 0; branch_neg = 0;
    endtask

    task automatic load(input logic [7:0] v);
        idle_in();
        adh_pch = 1; adh = v;
        tick();
        idle_in();
        pch_pch = 1;
    endtask

    initial begin
        // reset with junk on every input
        reset = 1; pch_pch = 1; adh_pch = 1; adh = 8'hA5; pclc = 1;
        branch_fix = 1; branch_carry = 1; branch_neg = 0;
        tick();
        chk("reset_pch", int'(o_pch), 8'h00);
        chk("reset_page_cross", int'(o_page_cross), 0);

        idle_in(); adh_pch = 1; adh = 8'hC0;
        tick();
        chk("adh_load", int'(o_pch), 8'hC0);

        load(8'h12);
        pclc = 1; #1;
        chk("inc_12_pchc", int'(o_pchc), 0);
        tick();
        chk("inc_12", int'(o_pch), 8'h13);

        load(8'hFF);
        pclc = 1; #1;
        chk("inc_ff_pchc", int'(o_pchc), 1);
        tick();
        chk("inc_ff_wrap", int'(o_pch), 8'h00);

        // forward page cross
        load(8'h80);
        branch_fix = 1; branch_carry = 1; branch_neg = 0;
        tick();
        chk("fwd_hold", int'(o_pch), 8'h80);
        chk("fwd_page_cross", int'(o_page_cross), 1);
        branch_fix = 0;
        tick();
        chk("fwd_fixed", int'(o_pch), 8'h81);
        chk("fwd_cross_clear", int'(o_page_cross), 0);

        // backward page cross with wrap 00 -> FF
        load(8'h00);
        branch_fix = 1; branch_carry = 0; branch_neg = 1;
        tick();
        branch_fix = 0; pclc = 1; #1;
        chk("bwd_page_cross", int'(o_page_cross), 1);
        chk("bwd_pchc_fix", int'(o_pchc), 0);
        tick();
        pclc = 0; #1;
        chk("bwd_fixed", int'(o_pch), 8'hFF);
        chk("bwd_pchc_after", int'(o_pchc), 0);

        // no crossing
        load(8'h80);
        branch_fix = 1; branch_carry = 1; branch_neg = 1;
        tick();
        chk("nocross_a", int'(o_page_cross), 0);
        branch_carry = 0; branch_neg = 0;
        tick();
        chk("nocross_b", int'(o_page_cross), 0);
        branch_fix = 0;
        tick();
        chk("nocross_pch", int'(o_pch), 8'h80);
        chk("nocross_c", int'(o_page_cross), 0);

        // reset in the FIX cycle aborts the fixup
        load(8'h40);
        branch_fix = 1; branch_carry = 1; branch_neg = 0;
        tick();
        chk("abort_in_fix", int'(o_page_cross), 1);
        idle_in(); reset = 1;
        tick();
        chk("abort_pch", int'(o_pch), 8'h00);
        chk("abort_cross", int'(o_page_cross), 0);
        idle_in(); pch_pch = 1;
        tick();
        chk("abort_stays", int'(o_pch), 8'h00);

        // FIX ignores select/increment and a second branch request
        load(8'h40);
        branch_fix = 1; branch_carry = 1; branch_neg = 0;
        tick();
        pch_pch = 0; adh_pch = 1; adh = 8'h55; pclc = 1;
        tick();
        chk("fix_ignores", int'(o_pch), 8'h41);
        chk("fix_second_req", int'(o_page_cross), 0);
        idle_in(); pch_pch = 1;
        tick();
        chk("fix_no_refix", int'(o_pch), 8'h41);

        // randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 49) == 0);
            pch_pch      = ($urandom_range(0, 3) != 0);
            adh_pch      = $urandom_range(0, 1);
            adh          = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            pclc         = $urandom_range(0, 1);
            branch_fix   = ($urandom_range(0, 2) == 0);
            branch_carry = $urandom_range(0, 1);
            branch_neg   = $urandom_range(0, 1);
            tick();
        end

        idle_in();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
